// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one combinational W x W multiplier among NREQ
// requesters through valid/ready handshakes and returns the product with its ID.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b/req_signed    per-requester operand pair, lane i at [i*W +: W]
//   rr_mode                   0 = fixed priority (lowest index), 1 = round robin
//   mul_a/mul_b/mul_signed    registered operands to the external multiplier
//   mul_p                     product from the external multiplier
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_product        winner index and captured product
//   busy                      high while an operation is in flight (CALC, RESP)
//   done_count                completed responses, saturating at 255
`timescale 1ns/1ps

module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_signed,
    input  logic              rr_mode,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_signed,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_product,
    output logic              busy,
    output logic [7:0]        done_count
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t state;

    logic [IDW-1:0]  last_id;
    logic [IDW-1:0]  op_id;
    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] above_last;
    logic [NREQ-1:0] rr_pool;
    logic            grant_en;
    logic            take;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_s;

    // Index of the lowest set bit; callers only use it when v is non-zero.
    function automatic logic [IDW-1:0] lowest(input logic [NREQ-1:0] v);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = IDW'(i);
            end
        end
        return id;
    endfunction

    // Round robin: prefer requesters above the last winner, otherwise wrap
    // around to the lowest pending index.
    always_comb begin
        above_last = '0;
        for (int i = 0; i < NREQ; i++) begin
            above_last[i] = (i > int'(last_id));
        end
    end

    assign rr_pool = req_valid & above_last;

    always_comb begin
        win_id = lowest(req_valid);
        if (rr_mode && (|rr_pool)) begin
            win_id = lowest(rr_pool);
        end
    end

    assign grant_en = (state == IDLE) && !rst && (|req_valid);

    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            for (int i = 0; i < NREQ; i++) begin
                req_ready[i] = (IDW'(i) == win_id);
            end
        end
    end

    assign take = |(req_valid & req_ready);

    // One-hot operand select driven by the grant itself.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_a = sel_a | req_a[i*W +: W];
                sel_b = sel_b | req_b[i*W +: W];
                sel_s = sel_s | req_signed[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_id     <= IDW'(NREQ - 1);
            op_id       <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_signed  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            busy        <= 1'b0;
            done_count  <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Operand registers double as the multiplier drive and
                    // keep their value after the op completes.
                    if (take) begin
                        mul_a      <= sel_a;
                        mul_b      <= sel_b;
                        mul_signed <= sel_s;
                        op_id      <= win_id;
                        last_id    <= win_id;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    rsp_product <= mul_p;
                    rsp_id      <= op_id;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        if (done_count != 8'hFF) begin
                            done_count <= done_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: table-driven, directed and randomized checks of
// mul_share_arbiter with a behavioural multiplier and reference model.
`timescale 1ns/1ps

module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic              rr_mode;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_signed;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_product;
    logic              busy;
    logic [7:0]        done_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_done = 0;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        bit         s;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[8];

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .rr_mode     (rr_mode),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_signed  (mul_signed),
        .mul_p       (mul_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    // Plain integer arithmetic, truncated to the product width.
    function automatic logic [7:0] mul_ref(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input bit s);
        int x;
        int y;
        x = int'(a);
        y = int'(b);
        if (s && a[3]) x = x - 16;
        if (s && b[3]) y = y - 16;
        return 8'(x * y);
    endfunction

    assign mul_p = mul_ref(mul_a, mul_b, mul_signed);

    function automatic logic [3:0] onehot(input int w);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == w) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Winner under the arbitration rules; -1 when nothing is pending.
    function automatic int arb(input logic [3:0] v, input int last,
                               input bit rr);
        if (v == 4'b0) return -1;
        if (!rr) begin
            for (int i = 0; i < NREQ; i++) begin
                if (v[i]) return i;
            end
        end
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst       = 1'b1;
        req_valid = '0;
        next_cycle();
        rst      = 1'b0;
        exp_done = 0;
    endtask

    task automatic run_op(input vec_t v);
        next_cycle();
        req_valid  = onehot(v.id);
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == v.id) begin
                req_a[i*W +: W] = v.a;
                req_b[i*W +: W] = v.b;
                req_signed[i]   = v.s;
            end
        end
        rr_mode   = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("tbl_grant", req_ready, onehot(v.id));
        next_cycle();
        req_valid = '0;
        #1;
        check("tbl_mul_a", mul_a, v.a);
        check("tbl_mul_b", mul_b, v.b);
        check("tbl_mul_signed", mul_signed, v.s);
        check("tbl_busy_calc", busy, 1);
        check("tbl_rspv_calc", rsp_valid, 0);
        next_cycle();
        #1;
        check("tbl_rsp_valid", rsp_valid, 1);
        check("tbl_rsp_id", rsp_id, v.id);
        check("tbl_rsp_product", rsp_product, v.p);
        next_cycle();
        exp_done++;
        #1;
        check("tbl_rspv_after", rsp_valid, 0);
        check("tbl_busy_after", busy, 0);
        check("tbl_done", done_count, exp_done);
    endtask

    // Reference model state for the random phase.
    bit         m_busy;
    int         m_age;
    int         m_last;
    int         m_done;
    int         m_id;
    logic [3:0] m_a;
    logic [3:0] m_b;
    bit         m_s;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        logic [3:0] exp_rdy;
        int         w;

        vecs[0] = '{id: 0, a: 4'd13, b: 4'd5,  s: 1'b0, p: 8'h41};
        vecs[1] = '{id: 2, a: 4'hD,  b: 4'd5,  s: 1'b1, p: 8'hF1};
        vecs[2] = '{id: 1, a: 4'hF,  b: 4'hF,  s: 1'b0, p: 8'hE1};
        vecs[3] = '{id: 3, a: 4'hF,  b: 4'hF,  s: 1'b1, p: 8'h01};
        vecs[4] = '{id: 0, a: 4'h8,  b: 4'h8,  s: 1'b1, p: 8'h40};
        vecs[5] = '{id: 1, a: 4'h8,  b: 4'h7,  s: 1'b1, p: 8'hC8};
        vecs[6] = '{id: 2, a: 4'h0,  b: 4'h9,  s: 1'b0, p: 8'h00};
        vecs[7] = '{id: 3, a: 4'h7,  b: 4'h9,  s: 1'b1, p: 8'hCF};

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        rr_mode    = 1'b0;
        rsp_ready  = 1'b0;

        // Reset state, and no grant while reset is asserted.
        next_cycle();
        next_cycle();
        req_valid = 4'b1111;
        #1;
        check("ready_in_reset", req_ready, 0);
        next_cycle();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_mul_signed", mul_signed, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_product", rsp_product, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_count, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
        end

        // Fixed priority: requester 1 wins every time, 3 starves.
        do_reset();
        req_valid  = 4'b1110;
        req_a      = {4{4'd2}};
        req_b      = {4{4'd3}};
        req_signed = '0;
        rr_mode    = 1'b0;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fp_grant", req_ready, 4'b0010);
            next_cycle();
            #1;
            check("fp_ready_calc", req_ready, 0);
            next_cycle();
            #1;
            check("fp_rsp_id", rsp_id, 1);
            next_cycle();
        end
        #1;
        check("fp_done", done_count, 3);

        // Round robin from reset: 0,1,2,3,0, one op every 3 cycles.
        do_reset();
        req_valid = 4'b1111;
        rr_mode   = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", req_ready, onehot(k % NREQ));
            next_cycle();
            #1;
            check("rr_ready_calc", req_ready, 0);
            next_cycle();
            #1;
            check("rr_rsp_id", rsp_id, k % NREQ);
            check("rr_ready_resp", req_ready, 0);
            next_cycle();
        end

        // Back-pressure: last winner was 0, so requester 1 goes next.
        req_a      = {4{4'd6}};
        req_b      = {4{4'd3}};
        req_signed = '0;
        rsp_ready  = 1'b0;
        #1;
        check("bp_grant", req_ready, 4'b0010);
        next_cycle();
        next_cycle();
        #1;
        check("bp_rsp_id", rsp_id, 1);
        check("bp_product", rsp_product, 8'h12);
        held = rsp_product;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_product_hold", rsp_product, held);
            check("bp_req_ready", req_ready, 0);
            check("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        next_cycle();
        #1;
        check("bp_release_rspv", rsp_valid, 0);
        check("bp_release_busy", busy, 0);
        check("bp_next_grant", req_ready, 4'b0100);

        // Reset while in CALC discards the op and restores priority to 0.
        next_cycle();
        #1;
        check("rc_mul_a", mul_a, 6);
        check("rc_busy", busy, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rc_mul_a_clr", mul_a, 0);
        check("rc_mul_b_clr", mul_b, 0);
        check("rc_rsp_valid", rsp_valid, 0);
        check("rc_rsp_product", rsp_product, 0);
        check("rc_busy_clr", busy, 0);
        check("rc_done_clr", done_count, 0);
        check("rc_grant0", req_ready, 4'b0001);

        // Saturation of the completion counter.
        do_reset();
        req_valid = 4'b0001;
        rr_mode   = 1'b0;
        rsp_ready = 1'b1;
        repeat (260 * 3) next_cycle();
        #1;
        check("sat_done", done_count, 255);

        // Randomized phase against the reference model.
        do_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_last = NREQ - 1;
        m_done = 0;
        m_id   = 0;
        m_a    = '0;
        m_b    = '0;
        m_s    = 1'b0;
        for (int c = 0; c < 800; c++) begin
            req_valid  = ($urandom_range(0, 3) == 0) ? 4'b0 :
                         4'($urandom_range(0, 15));
            req_a      = 16'($urandom);
            req_b      = 16'($urandom);
            req_signed = 4'($urandom_range(0, 15));
            rr_mode    = 1'($urandom_range(0, 1));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            #1;
            w       = m_busy ? -1 : arb(req_valid, m_last, rr_mode);
            exp_rdy = (w >= 0) ? onehot(w) : 4'b0;
            check("rnd_ready", req_ready, exp_rdy);
            check("rnd_busy", busy, m_busy);
            check("rnd_done", done_count, m_done);
            check("rnd_rsp_valid", rsp_valid, (m_busy && m_age == 2));
            if (m_busy && m_age == 1) begin
                check("rnd_mul_a", mul_a, m_a);
                check("rnd_mul_b", mul_b, m_b);
                check("rnd_mul_signed", mul_signed, m_s);
            end
            if (m_busy && m_age == 2) begin
                check("rnd_rsp_id", rsp_id, m_id);
                check("rnd_rsp_product", rsp_product, mul_ref(m_a, m_b, m_s));
            end
            if (!m_busy) begin
                if (w >= 0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (i == w) begin
                            m_a = req_a[i*W +: W];
                            m_b = req_b[i*W +: W];
                            m_s = req_signed[i];
                        end
                    end
                    m_id   = w;
                    m_last = w;
                    m_busy = 1'b1;
                    m_age  = 1;
                end
            end else if (m_age == 2) begin
                if (rsp_ready) begin
                    m_busy = 1'b0;
                    if (m_done < 255) m_done++;
                end
            end else begin
                m_age = 2;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
